// File: rtl/ysyx_041461_booth_mul_seq_if.sv
// Handshake bundle for the iterative radix-4 Booth multiplier.
// master = requester/consumer side, slave = the multiplier itself.
interface ysyx_041461_booth_mul_seq_if #(
  parameter int W = 64
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_a_signed;
  logic           in_b_signed;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;

  modport master (
    output in_valid, in_a, in_b, in_a_signed, in_b_signed, flush, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_a, in_b, in_a_signed, in_b_signed, flush, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/ysyx_041461_booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one recoded digit per CALC cycle, 2*W-bit product.
// Optional early exit on an exhausted multiplier: define YSYX_041461_BOOTH_EARLY_OUT_EN.
module ysyx_041461_booth_mul_seq #(
  parameter int W = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ysyx_041461_booth_mul_seq_if.slave   bus
);
  localparam int CW = $clog2(W/2 + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] out_p_q;
  logic [W+2:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           in_ready_q;
  logic           out_valid_q;

  logic           neg;
  logic           dbl;
  logic           nz;
  logic [2*W-1:0] pp;
  logic [2*W-1:0] pp_sh;
  logic [2*W-1:0] acc_next;
  logic           last;
  logic           early;
  logic [2*W-1:0] a_ext;
  logic [1:0]     ext2;

  // Booth recoding of the current window {y_add, y, y_sub}.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    neg = 1'b0;
    dbl = 1'b0;
    nz  = 1'b1;
    unique case (mplier[2:0])
      3'b000, 3'b111: nz = 1'b0;
      3'b001, 3'b010: ;
      3'b011:         dbl = 1'b1;
      3'b100:         begin dbl = 1'b1; neg = 1'b1; end
      3'b101, 3'b110: neg = 1'b1;
      default:        nz = 1'b0;
    endcase
  end

  // Negation as ~pp + 1 with the carry folded into the same adder.
  assign pp       = !nz ? '0 : (dbl ? (mcand << 1) : mcand);
  assign pp_sh    = pp << {cnt, 1'b0};
  assign acc_next = acc + (pp_sh ^ {(2*W){neg}}) + {{(2*W-1){1'b0}}, neg};
  assign last     = (cnt == CW'(W/2));

`ifdef YSYX_041461_BOOTH_EARLY_OUT_EN
  // Remaining windows are all 000 or 111 once the surviving bits are uniform.
  assign early = (&mplier[W+2:2]) | ~(|mplier[W+2:2]);
`else
  assign early = 1'b0;
`endif

  assign a_ext = bus.in_a_signed ? {{W{bus.in_a[W-1]}}, bus.in_a} : {{W{1'b0}}, bus.in_a};
  assign ext2  = bus.in_b_signed ? {2{bus.in_b[W-1]}} : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mcand       <= '0;
      acc         <= '0;
      out_p_q     <= '0;
      mplier      <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state       <= IDLE;
      out_p_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand      <= a_ext;
            mplier     <= {ext2, bus.in_b, 1'b0};
            acc        <= '0;
            cnt        <= '0;
            state      <= CALC;
            in_ready_q <= 1'b0;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= {{2{mplier[W+2]}}, mplier[W+2:2]};
          cnt    <= cnt + CW'(1);
          if (last || early) begin
            state       <= DONE;
            out_p_q     <= acc_next;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Handoff returns to IDLE; the next accept can only happen a cycle later.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = out_p_q;
endmodule

// File: tb/tb_ysyx_041461_booth_mul_seq.sv
// Directed bench for the Booth multiplier: exact-product model, latency, backpressure, flush, reset.
module tb_ysyx_041461_booth_mul_seq;
  localparam int W = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ysyx_041461_booth_mul_seq_if #(.W(W)) ifc ();

  ysyx_041461_booth_mul_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic         exp_active = 1'b0;
  logic [127:0] exp_p = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact product of the extended operands, modulo 2^128.
  function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic as, input logic bs);
    logic [127:0] ea;
    logic [127:0] eb;
    ea = as ? {{64{a[63]}}, a} : {64'b0, a};
    eb = bs ? {{64{b[63]}}, b} : {64'b0, b};
    return ea * eb;
  endfunction

  // Every cycle: a valid result must match the model, and no valid may appear with nothing in flight.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_active) begin
        if (ifc.out_valid) check("out_p_vs_model", ifc.out_p, exp_p);
      end else begin
        check("no_valid_when_idle", {127'b0, ifc.out_valid}, 128'b0);
      end
    end
  end

  task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic as, input logic bs);
    @(negedge clk);
    check("in_ready_before_accept", ifc.in_ready, 1);
    ifc.in_valid    = 1'b1;
    ifc.in_a        = a;
    ifc.in_b        = b;
    ifc.in_a_signed = as;
    ifc.in_b_signed = bs;
    exp_p           = model(a, b, as, bs);
    exp_active      = 1'b1;
    @(negedge clk);
    check("in_ready_busy", ifc.in_ready, 0);
    ifc.in_valid = 1'b0;
    ifc.in_a     = {$urandom, $urandom};
    ifc.in_b     = {$urandom, $urandom};
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic as, input logic bs,
                       input int hold, input bit noisy, input bit has_lit, input logic [127:0] lit);
    int           lat;
    logic [127:0] first;
    accept(a, b, as, bs);
    lat = 1;
    if (noisy) ifc.in_valid = 1'b1;
    while (!ifc.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if (noisy) begin
        ifc.in_a = {$urandom, $urandom};
        ifc.in_b = {$urandom, $urandom};
      end
    end
    ifc.in_valid = 1'b0;
    if (!ifc.out_valid) begin
      check("out_valid_timeout", 0, 1);
    end else begin
      check("latency", lat, 34);
      if (has_lit) begin
        check("model_pin", model(a, b, as, bs), lit);
        check("literal_product", ifc.out_p, lit);
      end
      first = ifc.out_p;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_out_valid", ifc.out_valid, 1);
        check("hold_in_ready", ifc.in_ready, 0);
        check("hold_out_p_stable", ifc.out_p, first);
      end
      ifc.out_ready = 1'b1;
      @(negedge clk);
      ifc.out_ready = 1'b0;
      check("handoff_out_valid", ifc.out_valid, 0);
      check("handoff_in_ready", ifc.in_ready, 1);
    end
    exp_active = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.in_valid    = 1'b0;
    ifc.in_a        = '0;
    ifc.in_b        = '0;
    ifc.in_a_signed = 1'b0;
    ifc.in_b_signed = 1'b0;
    ifc.flush       = 1'b0;
    ifc.out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", ifc.in_ready, 1);
    check("reset_out_valid", ifc.out_valid, 0);
    check("reset_out_p", ifc.out_p, 0);
    rst_n = 1'b1;

    // Hand-computed products.
    do_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1, 1, 0, 0, 1,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 1,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 1,
          128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001);
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 1, 0, 0, 1,
          128'h4000_0000_0000_0000_0000_0000_0000_0000);
    do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 1,
          128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000);

    // Model-only patterns, with backpressure and ignored in_valid while busy.
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1, 1, 10, 0, 0, '0);
    do_op(64'hDEAD_BEEF_0BAD_F00D, 64'h8000_0000_0000_0000, 1, 1, 0, 1, 0, '0);
    do_op(64'hC0FF_EE00_1234_5678, 64'hF0F0_F0F0_0F0F_0F0F, 0, 1, 3, 1, 0, '0);
    do_op(64'h0000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 0, '0);

    // Flush in CALC cycle 5 clears out_p and never produces a result.
    accept(64'd5, 64'd7, 1, 1);
    repeat (4) @(negedge clk);
    ifc.flush  = 1'b1;
    exp_active = 1'b0;
    @(negedge clk);
    ifc.flush = 1'b0;
    check("flush_in_ready", ifc.in_ready, 1);
    check("flush_out_valid", ifc.out_valid, 0);
    check("flush_out_p", ifc.out_p, 0);
    repeat (40) @(negedge clk);

    // Flush with a simultaneous request: the request is dropped.
    ifc.in_valid = 1'b1;
    ifc.flush    = 1'b1;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.flush    = 1'b0;
    check("flush_beats_accept", ifc.in_ready, 1);
    repeat (40) @(negedge clk);

    // Flush in DONE together with out_ready.
    accept(64'd11, 64'd13, 0, 0);
    for (int i = 0; i < 200 && !ifc.out_valid; i++) @(negedge clk);
    check("done_reached", ifc.out_valid, 1);
    ifc.out_ready = 1'b1;
    ifc.flush     = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    ifc.flush     = 1'b0;
    exp_active    = 1'b0;
    check("flush_done_out_valid", ifc.out_valid, 0);
    check("flush_done_in_ready", ifc.in_ready, 1);
    check("flush_done_out_p", ifc.out_p, 0);

    // Leave a nonzero out_p, then reset in the middle of the next operation.
    do_op(64'd100, 64'd200, 0, 0, 0, 0, 1, 128'd20000);
    accept(64'd9, 64'd9, 1, 1);
    repeat (10) @(negedge clk);
    rst_n      = 1'b0;
    exp_active = 1'b0;
    @(negedge clk);
    check("midop_reset_in_ready", ifc.in_ready, 1);
    check("midop_reset_out_valid", ifc.out_valid, 0);
    check("midop_reset_out_p", ifc.out_p, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    do_op(64'd2, 64'd3, 1, 1, 0, 0, 1, 128'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
